ps2_paddle_decoder: RTL and testbench

Receives raw PS/2 keyboard frames, checks them, and turns scan codes into the one-hot `paddle_movement` command and the `ps2_data_out` byte. It sits between the keyboard pins and the paddle movement logic. It tracks make/break codes for R, F, Y and H so that a paddle command stays asserted only while its key is held. It also emits a pause-toggle pulse for the space bar.

---
 rtl/ps2_paddle_decoder.sv | 168 ++++++++++++++++
 tb/tb_ps2_paddle_decoder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_paddle_decoder.sv
// PS/2 frame receiver and paddle scan-code decoder.
// Receives 11-bit PS/2 frames, validates start/parity/stop, and maps the
// R/F/Y/H make/break codes to a one-hot paddle command; space pulses stand_toggle.
module ps2_paddle_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset_to_start,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] ps2_data_out,
  output logic       ps2_data_valid,
  output logic       frame_error,
  output logic [3:0] paddle_movement,
  output logic       stand_toggle
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  state_t      state, state_nxt;
  logic        clk_s1, clk_s2, clk_s3;
  logic        dat_s1, dat_s2;
  logic        fall;
  logic [2:0]  bit_cnt, bit_cnt_nxt;
  logic [7:0]  shift, shift_nxt;
  logic        par_bit, par_bit_nxt;
  logic [15:0] to_cnt;
  logic        timeout, good_frame, bad_frame;
  logic [3:0]  held;        // [3]=R [2]=F [1]=Y [0]=H
  logic        brk_pend, ext_pend, tog_pre;

  assign fall = clk_s3 & ~clk_s2;

  // Synchronizers; reset to idle-high so reset never fakes a falling edge
  always_ff @(posedge clk) begin
    if (reset_to_start) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      clk_s3 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      clk_s3 <= clk_s2;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  // Frame state register and receive datapath
  always_ff @(posedge clk) begin
    if (reset_to_start) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shift   <= '0;
      par_bit <= 1'b0;
      to_cnt  <= '0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      shift   <= shift_nxt;
      par_bit <= par_bit_nxt;
      if (fall || state == IDLE)
        to_cnt <= '0;
      else if (to_cnt != '1)
        to_cnt <= to_cnt + 16'd1;
    end
  end

  // Next-state logic: bit sampling, frame checking and timeout abandonment
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift;
    par_bit_nxt = par_bit;
    good_frame  = 1'b0;
    bad_frame   = 1'b0;
    timeout     = (state != IDLE) && !fall && (to_cnt >= TIMEOUT_LIMIT);
    if (timeout) begin
      state_nxt   = IDLE;
      shift_nxt   = '0;
      bit_cnt_nxt = '0;
    end else if (fall) begin
      case (state)
        IDLE: begin
          if (!dat_s2) begin
            state_nxt   = DATA;
            bit_cnt_nxt = '0;
          end else begin
            bad_frame = 1'b1;
          end
        end
        DATA: begin
          shift_nxt   = {dat_s2, shift[7:1]};
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nxt = PARITY;
        end
        PARITY: begin
          par_bit_nxt = dat_s2;
          state_nxt   = STOP;
        end
        STOP: begin
          if (dat_s2 && (^{shift, par_bit})) good_frame = 1'b1;
          else                               bad_frame  = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Registered byte/error outputs and make/break key tracking
  always_ff @(posedge clk) begin
    if (reset_to_start) begin
      ps2_data_out   <= '0;
      ps2_data_valid <= 1'b0;
      frame_error    <= 1'b0;
      held           <= '0;
      brk_pend       <= 1'b0;
      ext_pend       <= 1'b0;
      tog_pre        <= 1'b0;
    end else begin
      ps2_data_valid <= good_frame;
      frame_error    <= bad_frame | timeout;
      tog_pre        <= 1'b0;
      if (good_frame) begin
        ps2_data_out <= shift;
        if (shift == 8'hF0) begin
          brk_pend <= 1'b1;
        end else if (shift == 8'hE0) begin
          ext_pend <= 1'b1;
        end else begin
          if (!ext_pend) begin
            case (shift)
              8'h2D:   held[3] <= ~brk_pend;
              8'h2B:   held[2] <= ~brk_pend;
              8'h35:   held[1] <= ~brk_pend;
              8'h33:   held[0] <= ~brk_pend;
              8'h29:   tog_pre <= ~brk_pend;
              default: ;
            endcase
          end
          brk_pend <= 1'b0;
          ext_pend <= 1'b0;
        end
      end
    end
  end

  // Priority-encode held keys (R > F > Y > H) and delay the toggle pulse
  always_ff @(posedge clk) begin
    if (reset_to_start) begin
      paddle_movement <= '0;
      stand_toggle    <= 1'b0;
    end else begin
      stand_toggle <= tog_pre;
      if      (held[3]) paddle_movement <= 4'b1000;
      else if (held[2]) paddle_movement <= 4'b0100;
      else if (held[1]) paddle_movement <= 4'b0010;
      else if (held[0]) paddle_movement <= 4'b0001;
      else              paddle_movement <= 4'b0000;
    end
  end

endmodule

// File: tb/tb_ps2_paddle_decoder.sv
// Scoreboard testbench for ps2_paddle_decoder.
module tb_ps2_paddle_decoder;

  localparam int unsigned HALF = 10;  // PS/2 clock half period in clk cycles

  logic       clk = 1'b0;
  logic       reset_to_start = 1'b1;
  logic       ps2_clk_pin = 1'b1;
  logic       ps2_data_pin = 1'b1;
  logic [7:0] ps2_data_out;
  logic       ps2_data_valid;
  logic       frame_error;
  logic [3:0] paddle_movement;
  logic       stand_toggle;

  ps2_paddle_decoder #(.TIMEOUT_CYCLES(100)) dut (
    .clk             (clk),
    .reset_to_start  (reset_to_start),
    .ps2_clk         (ps2_clk_pin),
    .ps2_data        (ps2_data_pin),
    .ps2_data_out    (ps2_data_out),
    .ps2_data_valid  (ps2_data_valid),
    .frame_error     (frame_error),
    .paddle_movement (paddle_movement),
    .stand_toggle    (stand_toggle)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] b;
    logic [3:0] pad;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   err_seen = 0, exp_err = 0;
  int   tog_seen = 0, exp_tog = 0;

  // reference model state
  logic [3:0] m_held = '0;
  logic       m_brk = 1'b0, m_ext = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [3:0] m_pad();
    if (m_held[3]) return 4'b1000;
    if (m_held[2]) return 4'b0100;
    if (m_held[1]) return 4'b0010;
    if (m_held[0]) return 4'b0001;
    return 4'b0000;
  endfunction

  task automatic model_byte(input logic [7:0] b);
    if (b == 8'hF0) m_brk = 1'b1;
    else if (b == 8'hE0) m_ext = 1'b1;
    else begin
      if (!m_ext) begin
        if (b == 8'h2D) m_held[3] = !m_brk;
        if (b == 8'h2B) m_held[2] = !m_brk;
        if (b == 8'h35) m_held[1] = !m_brk;
        if (b == 8'h33) m_held[0] = !m_brk;
        if (b == 8'h29 && !m_brk) exp_tog++;
      end
      m_brk = 1'b0;
      m_ext = 1'b0;
    end
    sb.push_back('{b: b, pad: m_pad()});
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data_pin = b;
    repeat (HALF/2) @(posedge clk);
    #1 ps2_clk_pin = 1'b0;
    repeat (HALF) @(posedge clk);
    #1 ps2_clk_pin = 1'b1;
    repeat (HALF/2) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_parity);
    logic p;
    p = ~(^b) ^ bad_parity;
    if (bad_parity) exp_err++;
    else model_byte(b);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(p);
    ps2_bit(1'b1);
  endtask

  task automatic settle(input string tag);
    repeat (30) @(posedge clk);
    #1;
    check({tag, "_err"}, err_seen, exp_err);
    check({tag, "_tog"}, tog_seen, exp_tog);
    check({tag, "_pad"}, {28'd0, paddle_movement}, {28'd0, m_pad()});
    check({tag, "_sb"}, sb.size(), 0);
  endtask

  // Output monitor: pops the scoreboard on each valid pulse
  logic valid_prev = 1'b0;
  logic pad_pend = 1'b0;
  logic [3:0] pad_exp = '0;
  always @(negedge clk) begin
    if (!reset_to_start) begin
      if (pad_pend) begin
        check("pad_e2", {28'd0, paddle_movement}, {28'd0, pad_exp});
        pad_pend = 1'b0;
      end
      if (valid_prev) check("valid_width", {31'd0, ps2_data_valid}, 32'd0);
      if (ps2_data_valid && !valid_prev) begin
        if (sb.size() == 0) begin
          check("spurious_valid", {31'd0, ps2_data_valid}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("data_out", {24'd0, ps2_data_out}, {24'd0, e.b});
          pad_exp  = e.pad;
          pad_pend = 1'b1;
        end
      end
      if (frame_error) err_seen++;
      if (stand_toggle) tog_seen++;
    end
    valid_prev = ps2_data_valid;
  end

  initial begin
    int n;
    repeat (4) @(posedge clk);
    #1 reset_to_start = 1'b0;
    @(negedge clk);
    check("rst_data", {24'd0, ps2_data_out}, 32'd0);
    check("rst_pad", {28'd0, paddle_movement}, 32'd0);
    check("rst_flags", {29'd0, ps2_data_valid, frame_error, stand_toggle}, 32'd0);
    @(posedge clk); #1;

    send_frame(8'h2D, 1'b0);
    settle("make_r");
    send_frame(8'hF0, 1'b0);
    send_frame(8'h2D, 1'b0);
    settle("break_r");

    send_frame(8'h33, 1'b0); settle("make_h");
    send_frame(8'h35, 1'b0); settle("make_y");
    send_frame(8'hF0, 1'b0); send_frame(8'h35, 1'b0); settle("break_y");
    send_frame(8'h2B, 1'b0); settle("make_f");
    send_frame(8'hF0, 1'b0); send_frame(8'h2B, 1'b0);
    send_frame(8'hF0, 1'b0); send_frame(8'h33, 1'b0); settle("clear");

    send_frame(8'h2D, 1'b0);
    send_frame(8'h2D, 1'b0);  // typematic repeat keeps R held
    send_frame(8'h33, 1'b1);
    settle("parity");
    check("parity_data_kept", {24'd0, ps2_data_out}, 32'h2D);
    send_frame(8'hF0, 1'b0); send_frame(8'h2D, 1'b0); settle("release_r");

    // lone falling edge with data high is a bad start bit
    exp_err++;
    ps2_bit(1'b1);
    settle("bad_start");

    // timeout: start bit plus 3 data bits, then a 4th data bit with no more edges
    exp_err++;
    ps2_bit(1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(1'b1);
    ps2_data_pin = 1'b0;
    repeat (HALF/2) @(posedge clk);
    #1 ps2_clk_pin = 1'b0;
    n = 0;
    while (n < 300 && !frame_error) begin
      @(negedge clk);
      n++;
      if (n == HALF) ps2_clk_pin = 1'b1;
    end
    ps2_clk_pin = 1'b1;
    ps2_data_pin = 1'b1;
    check("timeout_latency_ok", {31'd0, (n >= 100 && n <= 108)}, 32'd1);
    settle("timeout");
    send_frame(8'h29, 1'b0);
    send_frame(8'h29, 1'b0);
    settle("space");
    check("space_data", {24'd0, ps2_data_out}, 32'h29);

    send_frame(8'hE0, 1'b0); send_frame(8'h2D, 1'b0); settle("ext");
    send_frame(8'h2D, 1'b0); settle("make_r2");

    // reset in the middle of a frame, between bits with ps2_clk high
    ps2_bit(1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(1'b0);
    @(posedge clk); #1 reset_to_start = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_to_start = 1'b0;
    ps2_data_pin = 1'b1;
    sb.delete();
    pad_pend = 1'b0;
    m_held = '0; m_brk = 1'b0; m_ext = 1'b0;
    @(negedge clk);
    check("mid_rst_data", {24'd0, ps2_data_out}, 32'd0);
    check("mid_rst_pad", {28'd0, paddle_movement}, 32'd0);
    settle("mid_rst");
    send_frame(8'h33, 1'b0);
    settle("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
